// File: rtl/cr_osf_latency_mc.sv
// Multi-channel OSF egress latency stamper: per tid channel, counts cycles from the
// RQE sot accept to a chosen STAT TLV beat, stamps that beat and reports the value.
package cr_structs;
    localparam logic [7:0] RQE  = 8'h10;
    localparam logic [7:0] STAT = 8'h20;
endpackage

module cr_osf_latency_mc #(
    parameter int         DATA_W    = 64,
    parameter int         TID_W     = 2,
    parameter int         N_CH      = 4,
    parameter int         CNT_W     = 24,
    parameter int         LAT_LSB   = 0,
    parameter int         STAT_WORD = 2,
    parameter logic [7:0] TYPE_RQE  = cr_structs::RQE,
    parameter logic [7:0] TYPE_STAT = cr_structs::STAT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_tvalid,
    input  logic                in_tlast,
    input  logic [TID_W-1:0]    in_tid,
    input  logic [DATA_W/8-1:0] in_tstrb,
    input  logic [7:0]          in_tuser,
    input  logic [DATA_W-1:0]   in_tdata,
    input  logic                mstr_rd,
    output logic                out_tvalid,
    output logic                out_tlast,
    output logic [TID_W-1:0]    out_tid,
    output logic [DATA_W/8-1:0] out_tstrb,
    output logic [7:0]          out_tuser,
    output logic [DATA_W-1:0]   out_tdata,
    input  logic                lat_en,
    input  logic [N_CH-1:0]     sat_clr,
    output logic                rpt_vld,
    output logic [TID_W-1:0]    rpt_ch,
    output logic [CNT_W-1:0]    rpt_lat,
    output logic [N_CH-1:0]     lat_sat,
    output logic                lat_abort,
    output logic [2*N_CH-1:0]   dbg_state
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_STAT, S_INSERT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           st      [N_CH];
    logic [CNT_W-1:0] cnt     [N_CH];
    logic [3:0]       idx     [N_CH];
    logic [CNT_W-1:0] cnt_inc [N_CH];
    logic [N_CH-1:0]  hit;
    logic [N_CH-1:0]  abort;
    logic [N_CH-1:0]  sat_evt;
    logic             acc;
    logic             sot;
    logic             eot;
    logic             is_rqe;
    logic             is_stat;
    logic             stamp_on;
    logic [CNT_W-1:0] stamp_val;

    // Handshake: a beat is accepted only when in_tvalid && mstr_rd in the same cycle;
    // only accepted beats move a channel FSM, while the counters run every cycle.
    assign acc     = in_tvalid && mstr_rd;
    assign sot     = (in_tuser == 8'h01);
    assign eot     = (in_tuser == 8'h02);
    assign is_rqe  = sot && (in_tdata[7:0] == TYPE_RQE);
    assign is_stat = sot && (in_tdata[7:0] == TYPE_STAT);

    assign out_tvalid = in_tvalid;
    assign out_tlast  = in_tlast;
    assign out_tid    = in_tid;
    assign out_tstrb  = in_tstrb;
    assign out_tuser  = in_tuser;

    always_comb begin
        hit       = '0;
        abort     = '0;
        sat_evt   = '0;
        stamp_on  = 1'b0;
        stamp_val = '0;
        dbg_state = '0;
        for (int c = 0; c < N_CH; c++) begin
            cnt_inc[c]         = (cnt[c] == CNT_MAX) ? CNT_MAX : cnt[c] + CNT_W'(1);
            hit[c]             = acc && (in_tid == TID_W'(c));
            abort[c]           = lat_en && hit[c] &&
                                 ((st[c] == S_WAIT && is_rqe) ||
                                  (st[c] == S_STAT && (eot || in_tlast)));
            sat_evt[c]         = lat_en && (st[c] != S_IDLE) && (cnt[c] == CNT_MAX);
            dbg_state[2*c +: 2] = st[c];
            // The stamp tracks the live count for as long as the beat is stalled.
            if (lat_en && in_tvalid && (in_tid == TID_W'(c)) && st[c] == S_INSERT) begin
                stamp_on  = 1'b1;
                stamp_val = cnt_inc[c];
            end
        end
    end

    always_comb begin
        out_tdata = in_tdata;
        if (stamp_on) begin
            out_tdata[LAT_LSB +: CNT_W] = stamp_val;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < N_CH; c++) begin
                st[c]  <= S_IDLE;
                cnt[c] <= '0;
                idx[c] <= '0;
            end
            rpt_vld   <= 1'b0;
            rpt_ch    <= '0;
            rpt_lat   <= '0;
            lat_sat   <= '0;
            lat_abort <= 1'b0;
        end else begin
            rpt_vld   <= stamp_on && acc;
            if (stamp_on && acc) begin
                rpt_ch  <= in_tid;
                rpt_lat <= stamp_val;
            end
            lat_abort <= |abort;
            lat_sat   <= sat_evt | (lat_sat & ~sat_clr);
            for (int c = 0; c < N_CH; c++) begin
                if (!lat_en) begin
                    st[c]  <= S_IDLE;
                    cnt[c] <= '0;
                    idx[c] <= '0;
                end else begin
                    case (st[c])
                        S_IDLE: begin
                            cnt[c] <= '0;
                            idx[c] <= '0;
                            if (hit[c] && is_rqe) begin
                                st[c]  <= S_WAIT;
                                cnt[c] <= CNT_W'(1);
                            end
                        end
                        S_WAIT: begin
                            cnt[c] <= cnt_inc[c];
                            if (hit[c] && is_rqe) begin
                                cnt[c] <= CNT_W'(1);
                            end else if (hit[c] && is_stat) begin
                                if (STAT_WORD == 1) begin
                                    st[c] <= S_INSERT;
                                end else begin
                                    st[c]  <= S_STAT;
                                    idx[c] <= 4'd1;
                                end
                            end
                        end
                        S_STAT: begin
                            cnt[c] <= cnt_inc[c];
                            if (hit[c]) begin
                                if (eot || in_tlast) begin
                                    st[c]  <= S_IDLE;
                                    cnt[c] <= '0;
                                    idx[c] <= '0;
                                end else begin
                                    idx[c] <= idx[c] + 4'd1;
                                    if (idx[c] + 4'd1 == 4'(STAT_WORD)) begin
                                        st[c] <= S_INSERT;
                                    end
                                end
                            end
                        end
                        S_INSERT: begin
                            cnt[c] <= cnt_inc[c];
                            if (hit[c]) begin
                                st[c]  <= S_IDLE;
                                cnt[c] <= '0;
                                idx[c] <= '0;
                            end
                        end
                        default: begin
                            st[c]  <= S_IDLE;
                            cnt[c] <= '0;
                            idx[c] <= '0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_cr_osf_latency_mc.sv
// Directed bench for cr_osf_latency_mc: a row table for the main stream scenarios
// plus hand sequences for saturation on a narrow-counter instance.
module tb_cr_osf_latency_mc;

    localparam logic [63:0] RQE_D  = {56'hAB_CDEF_0123_4567, cr_structs::RQE};
    localparam logic [63:0] STAT_D = {56'h11_2233_4455_6677, cr_structs::STAT};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        in_tvalid = 1'b0;
    logic        in_tlast = 1'b0;
    logic [1:0]  in_tid = '0;
    logic [7:0]  in_tstrb = '0;
    logic [7:0]  in_tuser = '0;
    logic [63:0] in_tdata = '0;
    logic        mstr_rd = 1'b0;
    logic        lat_en = 1'b1;
    logic [3:0]  sat_clr = '0;

    logic        out_tvalid, out_tlast, rpt_vld, lat_abort;
    logic [1:0]  out_tid, rpt_ch;
    logic [7:0]  out_tstrb, out_tuser, dbg_state;
    logic [63:0] out_tdata;
    logic [23:0] rpt_lat;
    logic [3:0]  lat_sat;

    logic        out4_tvalid, out4_tlast, rpt4_vld, lat4_abort;
    logic [1:0]  out4_tid, rpt4_ch;
    logic [7:0]  out4_tstrb, out4_tuser, dbg4_state;
    logic [63:0] out4_tdata;
    logic [3:0]  rpt4_lat;
    logic [3:0]  lat4_sat;

    cr_osf_latency_mc dut (
        .clk(clk), .rst_n(rst_n), .in_tvalid(in_tvalid), .in_tlast(in_tlast),
        .in_tid(in_tid), .in_tstrb(in_tstrb), .in_tuser(in_tuser), .in_tdata(in_tdata),
        .mstr_rd(mstr_rd), .out_tvalid(out_tvalid), .out_tlast(out_tlast),
        .out_tid(out_tid), .out_tstrb(out_tstrb), .out_tuser(out_tuser),
        .out_tdata(out_tdata), .lat_en(lat_en), .sat_clr(sat_clr), .rpt_vld(rpt_vld),
        .rpt_ch(rpt_ch), .rpt_lat(rpt_lat), .lat_sat(lat_sat), .lat_abort(lat_abort),
        .dbg_state(dbg_state)
    );

    cr_osf_latency_mc #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_tvalid(in_tvalid), .in_tlast(in_tlast),
        .in_tid(in_tid), .in_tstrb(in_tstrb), .in_tuser(in_tuser), .in_tdata(in_tdata),
        .mstr_rd(mstr_rd), .out_tvalid(out4_tvalid), .out_tlast(out4_tlast),
        .out_tid(out4_tid), .out_tstrb(out4_tstrb), .out_tuser(out4_tuser),
        .out_tdata(out4_tdata), .lat_en(lat_en), .sat_clr(sat_clr), .rpt_vld(rpt4_vld),
        .rpt_ch(rpt4_ch), .rpt_lat(rpt4_lat), .lat_sat(lat4_sat), .lat_abort(lat4_abort),
        .dbg_state(dbg4_state)
    );

    typedef struct {
        bit          rst;
        bit          en;
        bit          vld;
        bit          rd;
        bit          last;
        logic [1:0]  tid;
        logic [7:0]  user;
        logic [63:0] data;
        bit          stp;
        logic [23:0] lat;
        bit          ab;
    } vec_t;

    vec_t        vecs[$];
    logic [25:0] exp_q[$];
    logic [25:0] sb_e;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input bit rst, input bit en, input bit vld, input bit rd,
                       input bit last, input logic [1:0] tid, input logic [7:0] user,
                       input logic [63:0] data, input bit stp, input logic [23:0] lat,
                       input bit ab);
        vec_t v;
        v.rst = rst; v.en = en; v.vld = vld; v.rd = rd; v.last = last; v.tid = tid;
        v.user = user; v.data = data; v.stp = stp; v.lat = lat; v.ab = ab;
        vecs.push_back(v);
    endtask

    task automatic idle(input bit ab);
        add(1, 1, 0, 0, 0, 2'd0, 8'h00, 64'h0, 0, 24'd0, ab);
    endtask
    task automatic rqe(input logic [1:0] tid);
        add(1, 1, 1, 1, 0, tid, 8'h01, RQE_D, 0, 24'd0, 0);
    endtask
    task automatic stat(input logic [1:0] tid);
        add(1, 1, 1, 1, 0, tid, 8'h01, STAT_D, 0, 24'd0, 0);
    endtask
    task automatic beat(input logic [1:0] tid, input bit last, input logic [63:0] data,
                        input bit stp, input logic [23:0] lat, input bit ab);
        add(1, 1, 1, 1, last, tid, 8'h00, data, stp, lat, ab);
    endtask
    task automatic stall(input logic [1:0] tid, input logic [63:0] data, input logic [23:0] lat);
        add(1, 1, 1, 0, 0, tid, 8'h00, data, 1, lat, 0);
    endtask

    task automatic drive(input bit rst, input bit clr, input bit vld, input bit rd,
                         input logic [1:0] tid, input logic [7:0] user, input logic [63:0] data);
        @(negedge clk);
        rst_n     = rst;
        lat_en    = 1'b1;
        sat_clr   = {3'b000, clr};
        in_tvalid = vld;
        mstr_rd   = rd;
        in_tlast  = 1'b0;
        in_tid    = tid;
        in_tuser  = user;
        in_tstrb  = vld ? 8'hFF : 8'h00;
        in_tdata  = data;
        #2;
    endtask

    // Report scoreboard: every rpt_vld pulse must match the oldest expected stamp.
    always @(negedge clk) begin
        #3;
        if (rpt_vld === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rpt_unexpected: got ch=%0d lat=%0d want none", rpt_ch, rpt_lat);
            end else begin
                sb_e = exp_q.pop_front();
                check("rpt_ch_lat", {38'd0, rpt_ch, rpt_lat}, {38'd0, sb_e});
            end
        end
    end

    initial begin
        vec_t        v;
        logic [63:0] exp_d;
        bit          prev_rpt;

        // Case 1: single channel, stamp on STAT beat 2, 13 cycles inclusive.
        rqe(2'd0);
        for (int k = 0; k < 9; k++) idle(0);
        stat(2'd0);
        beat(2'd0, 0, 64'h0102_0304_0506_0708, 0, 24'd0, 0);
        beat(2'd0, 0, 64'hDEAD_BEEF_CAFE_F00D, 1, 24'd13, 0);
        idle(0);
        // Case 2: interleaved ch1/ch2.
        rqe(2'd1); idle(0); idle(0); rqe(2'd2); idle(0);
        stat(2'd1); stat(2'd2);
        beat(2'd1, 0, 64'h1111_0000_1111_0001, 0, 24'd0, 0);
        beat(2'd2, 0, 64'h2222_0000_2222_0001, 0, 24'd0, 0);
        beat(2'd1, 0, 64'h1111_AAAA_BBBB_CCCC, 1, 24'd10, 0);
        beat(2'd2, 0, 64'h2222_DDDD_EEEE_FFFF, 1, 24'd8, 0);
        idle(0);
        // Case 3: backpressure while in INSERT.
        rqe(2'd0); stat(2'd0);
        beat(2'd0, 0, 64'h3333_0000_0000_0001, 0, 24'd0, 0);
        for (int k = 0; k < 5; k++) stall(2'd0, 64'h3C3C_5A5A_9696_F0F0, 24'(4 + k));
        beat(2'd0, 0, 64'h3C3C_5A5A_9696_F0F0, 1, 24'd9, 0);
        idle(0);
        // Case 5a: second RQE on ch3 restarts the count.
        rqe(2'd3); idle(0); rqe(2'd3); idle(1);
        stat(2'd3);
        beat(2'd3, 0, 64'h5555_0000_0000_0001, 0, 24'd0, 0);
        beat(2'd3, 0, 64'h5555_1234_5678_9ABC, 1, 24'd5, 0);
        idle(0);
        // Case 5b: tlast on STAT word 1 aborts, later ch3 beat untouched.
        rqe(2'd3); stat(2'd3);
        beat(2'd3, 1, 64'h5B5B_0000_0000_0001, 0, 24'd0, 0);
        beat(2'd3, 0, 64'h5B5B_7777_8888_9999, 0, 24'd0, 1);
        idle(0);
        // Case 6a: reset while ch0 in STAT.
        rqe(2'd0); stat(2'd0);
        add(0, 1, 0, 0, 0, 2'd0, 8'h00, 64'h0, 0, 24'd0, 0);
        beat(2'd0, 0, 64'h6666_0000_0000_0001, 0, 24'd0, 0);
        beat(2'd0, 0, 64'h6666_ABAB_CDCD_EFEF, 0, 24'd0, 0);
        idle(0);
        // Case 6b: lat_en drop returns ch0 to IDLE with the counter cleared.
        rqe(2'd0); stat(2'd0);
        beat(2'd0, 0, 64'h6B6B_0000_0000_0001, 0, 24'd0, 0);
        add(1, 0, 0, 0, 0, 2'd0, 8'h00, 64'h0, 0, 24'd0, 0);
        beat(2'd0, 0, 64'h6B6B_1111_2222_3333, 0, 24'd0, 0);
        rqe(2'd0); stat(2'd0);
        beat(2'd0, 0, 64'h6B6B_0000_0000_0002, 0, 24'd0, 0);
        beat(2'd0, 0, 64'h6B6B_4444_5555_6666, 1, 24'd4, 0);
        idle(0);

        // Reset state
        drive(0, 0, 0, 0, 2'd0, 8'h00, 64'h0);
        drive(0, 0, 0, 0, 2'd0, 8'h00, 64'h0);
        check("reset_rpt", {37'd0, rpt_vld, rpt_ch, rpt_lat}, 64'h0);
        check("reset_flags", {59'd0, lat_abort, lat_sat}, 64'h0);
        check("reset_state", {56'd0, dbg_state}, 64'h0);

        prev_rpt = 1'b0;
        foreach (vecs[i]) begin
            v = vecs[i];
            @(negedge clk);
            rst_n     = v.rst;
            lat_en    = v.en;
            sat_clr   = 4'b0000;
            in_tvalid = v.vld;
            mstr_rd   = v.rd;
            in_tlast  = v.last;
            in_tid    = v.tid;
            in_tuser  = v.user;
            in_tstrb  = v.vld ? 8'hFF : 8'h00;
            in_tdata  = v.data;
            #2;
            exp_d = v.data;
            if (v.stp) exp_d[23:0] = v.lat;
            check($sformatf("tdata[%0d]", i), out_tdata, exp_d);
            check($sformatf("pass[%0d]", i), {44'd0, out_tvalid, out_tlast, out_tid, out_tstrb, out_tuser},
                  {44'd0, v.vld, v.last, v.tid, (v.vld ? 8'hFF : 8'h00), v.user});
            check($sformatf("rpt_vld[%0d]", i), {63'd0, rpt_vld}, {63'd0, prev_rpt});
            check($sformatf("abort[%0d]", i), {63'd0, lat_abort}, {63'd0, v.ab});
            check($sformatf("sat[%0d]", i), {60'd0, lat_sat}, 64'h0);
            prev_rpt = v.rst && v.en && v.stp && v.vld && v.rd;
            if (prev_rpt) exp_q.push_back({v.tid, v.lat});
        end

        // Case 4: narrow counter saturates; both instances see the same stream.
        drive(0, 0, 0, 0, 2'd0, 8'h00, 64'h0);
        drive(1, 0, 1, 1, 2'd0, 8'h01, RQE_D);
        for (int k = 1; k < 20; k++) drive(1, 0, 0, 0, 2'd0, 8'h00, 64'h0);
        drive(1, 0, 1, 1, 2'd0, 8'h01, STAT_D);
        drive(1, 0, 1, 1, 2'd0, 8'h00, 64'h4444_0000_0000_0001);
        drive(1, 0, 1, 1, 2'd0, 8'h00, 64'h4444_9876_5432_10AB);
        exp_d = 64'h4444_9876_5432_10AB;
        exp_d[3:0] = 4'hF;
        check("sat_stamp4", out4_tdata, exp_d);
        exp_d = 64'h4444_9876_5432_10AB;
        exp_d[23:0] = 24'd23;
        check("stamp_ref23", out_tdata, exp_d);
        exp_q.push_back({2'd0, 24'd23});
        drive(1, 0, 0, 0, 2'd0, 8'h00, 64'h0);
        check("rpt4", {57'd0, rpt4_vld, rpt4_ch, rpt4_lat}, {57'd0, 1'b1, 2'd0, 4'hF});
        check("lat_sat4_set", {60'd0, lat4_sat}, 64'h1);
        check("lat_sat_main", {60'd0, lat_sat}, 64'h0);
        drive(1, 1, 0, 0, 2'd0, 8'h00, 64'h0);
        drive(1, 0, 0, 0, 2'd0, 8'h00, 64'h0);
        check("lat_sat4_clr", {60'd0, lat4_sat}, 64'h0);
        drive(1, 0, 1, 1, 2'd0, 8'h01, RQE_D);
        for (int k = 1; k < 15; k++) drive(1, 0, 0, 0, 2'd0, 8'h00, 64'h0);
        drive(1, 1, 0, 0, 2'd0, 8'h00, 64'h0);
        check("lat_sat4_pre", {60'd0, lat4_sat}, 64'h0);
        drive(1, 0, 0, 0, 2'd0, 8'h00, 64'h0);
        check("lat_sat4_setwins", {60'd0, lat4_sat}, 64'h1);
        drive(1, 0, 0, 0, 2'd0, 8'h00, 64'h0);

        check("rpt_q_empty", 64'(exp_q.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cr_osf_latency_mc.md
Name: cr_osf_latency_mc

Overview:
- Multi-channel, parametrised successor of the OSF latency stamper.
- Sits on the OSF egress data-path stream, which carries interleaved frames from up to N_CH channels, selected by tid.
- For each channel it measures the cycles from the RQE start-of-TLV read to a configurable word of the STAT TLV, and overwrites a configurable latency field in that word.
- It also exports each measurement on a one-cycle report interface, with sticky saturation flags per channel.

Parameters:
- DATA_W, 64: tdata width.
- TID_W, 2: tid width. Channel index is tid[TID_W-1:0].
- N_CH, 4: number of channels; must be ≤ 2^TID_W.
- CNT_W, 24: latency counter width.
- LAT_LSB, 0: bit position of the latency field in the stamped word. LAT_LSB+CNT_W must be ≤ DATA_W.
- STAT_WORD, 2: beat index within the STAT TLV to stamp; legal range 1..15. Beat 0 is the sot beat.
- TYPE_RQE, cr_structs::RQE: tlv_type code of the request TLV.
- TYPE_STAT, cr_structs::STAT: tlv_type code of the stats TLV.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: synchronous active-low reset.
- in_tvalid, in, 1: input beat valid.
- in_tlast, in, 1: last beat of frame.
- in_tid, in, TID_W: channel id.
- in_tstrb, in, DATA_W/8: byte strobes.
- in_tuser, in, 8: 8'h1 = sot, 8'h2 = eot.
- in_tdata, in, DATA_W: data. tlv_type is tdata[7:0] on sot beats.
- mstr_rd, in, 1: downstream accepted the current beat. A beat counts only when mstr_rd=1 and in_tvalid=1.
- out_tvalid, out_tlast, out_tid, out_tstrb, out_tuser, out, same widths as inputs: combinational pass-through.
- out_tdata, out, DATA_W: pass-through, except the stamped beat.
- lat_en, in, 1: global enable. When 0, all channels are held in IDLE with counters cleared.
- sat_clr, in, N_CH: per-channel clear of the sticky sat flag.
- rpt_vld, out, 1: one-cycle pulse per stamped beat.
- rpt_ch, out, TID_W: channel of the report.
- rpt_lat, out, CNT_W: latency value written.
- lat_sat, out, N_CH: sticky flag, set when a channel counter saturates.
- lat_abort, out, 1: one-cycle pulse when a channel restarts before stamping.

Behaviour:
- Reset (synchronous, rst_n=0 at clk edge):
  - All channel FSMs go to IDLE.
  - All counters are 0 and all beat indices are 0.
  - rpt_vld=0, rpt_ch=0, rpt_lat=0, lat_sat=0, lat_abort=0.
  - Reset mid-frame simply abandons any measurement; nothing is stamped afterwards for that frame.
- Pass-through: every out_* signal equals its in_* counterpart combinationally (zero latency).
  - Exception: on the stamped beat, out_tdata[LAT_LSB+:CNT_W] = cnt+1, saturating at all-ones. All other bits pass unchanged.
- A per-channel FSM is kept for each channel c, with states IDLE / WAIT / STAT / INSERT, a CNT_W-bit counter cnt, and a 4-bit beat index.
  - "acc(c)" below means an accepted beat with in_tid==c. Non-c beats never change channel c's state.
- IDLE:
  - cnt is held at 0.
  - acc(c) with sot and tlv_type==TYPE_RQE: go to WAIT, cnt←1.
- WAIT:
  - cnt increments every cycle.
  - acc(c) with sot and tlv_type==TYPE_STAT: if STAT_WORD==1, go to INSERT; otherwise go to STAT with idx←1.
  - acc(c) with sot and TYPE_RQE: restart. cnt←1, stay in WAIT, pulse lat_abort next cycle.
- STAT:
  - cnt increments every cycle.
  - On acc(c): idx increments; when idx+1==STAT_WORD, go to INSERT.
  - No acc(c): hold state and idx.
- INSERT:
  - cnt increments every cycle.
  - The current channel-c beat with in_tvalid=1 is muxed (stamped).
  - On acc(c): stamp completes; go to IDLE, cnt←0.
    - Next cycle: rpt_vld=1, rpt_ch=c, rpt_lat = stamped value.
  - Stall (no acc(c)): remain in INSERT; the stamped value keeps tracking cnt+1.
- Channel c enters IDLE without stamping in these cases:
  - eot or tlast on acc(c) while in STAT or INSERT, before the stamp beat completes: pulse lat_abort.
  - lat_en=0.
- Saturation: cnt stops at 2^CNT_W-1 and lat_sat[c] is set.
  - sat_clr[c] clears lat_sat[c]. If sat_clr[c] and a new saturation occur in the same cycle, set wins.
- Reports: at most one stamp completes per cycle, since only one beat is accepted per cycle, so rpt_* carries no conflicts.
- lat_abort pulses coinciding from different channels are ORed into one pulse.
- Beats with in_tid ≥ N_CH pass through untouched and are never tracked.
- Counter arithmetic is unsigned modulo-free (saturating only). The stamped value equals the cycle count from the RQE accept cycle to the stamp accept cycle, inclusive.

Test Plan:
1. Ch0: RQE sot accepted at t=0, STAT sot accepted at t=10, then beats accepted at t=11 and t=12. Required: out_tdata[23:0] on the t=12 beat = 13; rpt_vld at t=13 with rpt_ch=0, rpt_lat=13; other bits of the beat unchanged.
2. Interleave ch1 and ch2: ch1 RQE at t=0, ch2 RQE at t=3, then each channel's STAT words. Required: each channel reports independently with correct counts; beats of the other channel are never stamped.
3. Backpressure: mstr_rd=0 for 5 cycles while ch0 is in INSERT. Required: out_tdata tracks cnt+1 during the stall; the final report equals the value present on the accepted cycle.
4. CNT_W=4, more than 15 cycles between RQE and the stamp. Required: stamp = 4'hF, lat_sat[0]=1. Then apply sat_clr[0] together with a new saturation. Required: lat_sat[0] stays 1.
5. Second RQE sot on ch3 while in WAIT. Required: lat_abort pulse, counter restarts at 1. Also: tlast on STAT word 1 with STAT_WORD=2 → abort, no stamp, no rpt_vld.
6. rst_n=0 while ch0 is in STAT, released for the remaining STAT beats. Required: no stamp, all outputs at reset values. Separately: lat_en=0 mid-frame → ch0 returns to IDLE.
